aw_split_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the write-address (AW) channel toward one slave port.

---
 rtl/aw_split_arbiter_pkg.sv | 12 +
 rtl/aw_split_arbiter_if.sv | 39 +++
 rtl/aw_split_arbiter_rr_priority_picker.sv | 31 +++
 rtl/aw_split_arbiter.sv | 95 +++++++++
 tb/tb_aw_split_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aw_split_arbiter_pkg.sv
// Shared definitions for the AW split arbiter: FSM encoding and AXI field widths.
package aw_split_arbiter_pkg;

    localparam int AXI_LEN_W  = 8;
    localparam int AXI_SIZE_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } aw_state_e;

endpackage

// File: rtl/aw_split_arbiter_if.sv
// AW request bundle between the masters, the arbiter and the slave port / W-ordering queue.
interface aw_split_arbiter_if
    import aw_split_arbiter_pkg::*;
#(
    parameter int Masters_Num = 2,
    parameter int ID_Size     = $clog2(Masters_Num),
    parameter int Addr_Width  = 32
);
    logic [Masters_Num-1:0]            M_AWVALID;
    logic [Masters_Num*Addr_Width-1:0] M_AWADDR;
    logic [Masters_Num*AXI_LEN_W-1:0]  M_AWLEN;
    logic [Masters_Num*AXI_SIZE_W-1:0] M_AWSIZE;
    logic [Masters_Num-1:0]            M_AWREADY;

    logic                              S_AWVALID;
    logic [Addr_Width-1:0]             S_AWADDR;
    logic [AXI_LEN_W-1:0]              S_AWLEN;
    logic [AXI_SIZE_W-1:0]             S_AWSIZE;
    logic                              S_AWREADY;

    logic                              Queue_Is_Full;
    logic                              AW_Access_Grant;
    logic [ID_Size-1:0]                Slave_ID;
    logic                              Is_Transaction_Part_of_Split;

    // slave: the arbiter's own view; master: everything around it
    modport slave (
        input  M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, S_AWREADY, Queue_Is_Full,
        output M_AWREADY, S_AWVALID, S_AWADDR, S_AWLEN, S_AWSIZE,
               AW_Access_Grant, Slave_ID, Is_Transaction_Part_of_Split
    );

    modport master (
        output M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, S_AWREADY, Queue_Is_Full,
        input  M_AWREADY, S_AWVALID, S_AWADDR, S_AWLEN, S_AWSIZE,
               AW_Access_Grant, Slave_ID, Is_Transaction_Part_of_Split
    );

endinterface

// File: rtl/aw_split_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester strictly after the last grant, wrapping.
module rr_priority_picker #(
    parameter int Masters_Num = 2,
    parameter int ID_Size     = $clog2(Masters_Num)
) (
    input  logic [Masters_Num-1:0] req,
    input  logic [ID_Size-1:0]     last,
    output logic                   any_req,
    output logic [ID_Size-1:0]     grant
);

    int   idx;
    logic found;

    assign any_req = |req;

    // Scanning offsets 1..N puts the last winner at the lowest priority
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= Masters_Num; i++) begin
            idx = (int'(last) + i) % Masters_Num;
            if (!found && req[idx]) begin
                grant = ID_Size'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aw_split_arbiter.sv
// Round-robin AW arbiter toward one slave port; splits long INCR bursts into sub-bursts
// and feeds the W-ordering queue with grant pulse, master index and split flag.
module aw_split_arbiter
    import aw_split_arbiter_pkg::*;
#(
    parameter int Masters_Num   = 2,
    parameter int ID_Size       = $clog2(Masters_Num),
    parameter int Addr_Width    = 32,
    parameter int Max_Burst_Len = 15
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    aw_split_arbiter_if.slave bus
);

    localparam logic [AXI_LEN_W-1:0]  MAX_LEN   = AXI_LEN_W'(Max_Burst_Len);
    localparam logic [AXI_LEN_W-1:0]  SUB_BEATS = AXI_LEN_W'(Max_Burst_Len + 1);
    localparam logic [Addr_Width-1:0] SUB_UNITS = Addr_Width'(Max_Burst_Len + 1);

    aw_state_e               state;
    logic [ID_Size-1:0]      rr_ptr;
    logic [ID_Size-1:0]      grant_id;
    logic [ID_Size-1:0]      pick_id;
    logic                    any_req;
    logic [Addr_Width-1:0]   addr_q;
    logic [AXI_LEN_W-1:0]    rem_q;
    logic [AXI_SIZE_W-1:0]   size_q;
    logic                    handshake;
    logic                    more;

    rr_priority_picker #(
        .Masters_Num (Masters_Num),
        .ID_Size     (ID_Size)
    ) u_picker (
        .req     (bus.M_AWVALID),
        .last    (rr_ptr),
        .any_req (any_req),
        .grant   (pick_id)
    );

    assign more      = rem_q > MAX_LEN;
    assign handshake = bus.S_AWVALID && bus.S_AWREADY;

    assign bus.S_AWVALID                    = (state == ISSUE) && !bus.Queue_Is_Full;
    assign bus.AW_Access_Grant              = handshake;
    assign bus.S_AWADDR                     = addr_q;
    assign bus.S_AWLEN                      = more ? MAX_LEN : rem_q;
    assign bus.S_AWSIZE                     = size_q;
    assign bus.Slave_ID                     = grant_id;
    assign bus.Is_Transaction_Part_of_Split = (state == ISSUE) && more;

    // The master is released only on the handshake of its final sub-burst
    always_comb begin
        bus.M_AWREADY = '0;
        if (handshake && !more) begin
            bus.M_AWREADY[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= IDLE;
            rr_ptr   <= ID_Size'(Masters_Num - 1);
            grant_id <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            size_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= pick_id;
                        addr_q   <= bus.M_AWADDR[pick_id*Addr_Width +: Addr_Width];
                        rem_q    <= bus.M_AWLEN[pick_id*AXI_LEN_W +: AXI_LEN_W];
                        size_q   <= bus.M_AWSIZE[pick_id*AXI_SIZE_W +: AXI_SIZE_W];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        if (more) begin
                            rem_q  <= rem_q - SUB_BEATS;
                            addr_q <= addr_q + (SUB_UNITS << size_q);
                        end else begin
                            rr_ptr <= grant_id;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aw_split_arbiter.sv
// Scoreboard bench for aw_split_arbiter: expected sub-bursts are queued when a master
// request is driven and compared on every AW_Access_Grant.
module tb_aw_split_arbiter;

    localparam int NM   = 2;
    localparam int IDW  = 1;
    localparam int AW   = 32;
    localparam int MAXL = 15;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;

    always #5 ACLK = ~ACLK;

    aw_split_arbiter_if #(.Masters_Num(NM), .ID_Size(IDW), .Addr_Width(AW)) bus ();

    aw_split_arbiter #(
        .Masters_Num   (NM),
        .ID_Size       (IDW),
        .Addr_Width    (AW),
        .Max_Burst_Len (MAXL)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    typedef struct {
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [IDW-1:0] id;
        logic           split;
    } exp_t;

    exp_t sb[$];
    int   grant_cyc[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   grants = 0;
    int   rep_left[NM];
    int   ready_cnt[NM];
    logic [NM-1:0] drop_req;

    logic           smp_vld;
    logic [AW-1:0]  smp_addr;
    logic [7:0]     smp_len;
    logic [IDW-1:0] smp_id;
    logic           smp_split;
    logic           smp_grant;
    logic [NM-1:0]  smp_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample at negedge, compare grants against the scoreboard, then apply master drops after posedge
    task automatic tick();
        exp_t          e;
        logic [NM-1:0] exp_rdy;
        @(negedge ACLK);
        cyc++;
        smp_vld   = bus.S_AWVALID;
        smp_addr  = bus.S_AWADDR;
        smp_len   = bus.S_AWLEN;
        smp_id    = bus.Slave_ID;
        smp_split = bus.Is_Transaction_Part_of_Split;
        smp_grant = bus.AW_Access_Grant;
        smp_rdy   = bus.M_AWREADY;
        if (smp_grant) begin
            grants++;
            grant_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_grant", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                exp_rdy = e.split ? '0 : (NM'(1) << e.id);
                chk("s_awaddr", 64'(smp_addr), 64'(e.addr));
                chk("s_awlen", 64'(smp_len), 64'(e.len));
                chk("slave_id", 64'(smp_id), 64'(e.id));
                chk("split_flag", 64'(smp_split), 64'(e.split));
                chk("m_awready", 64'(smp_rdy), 64'(exp_rdy));
            end
        end else if (smp_rdy != '0) begin
            chk("stray_m_awready", 64'(smp_rdy), 64'(0));
        end
        for (int i = 0; i < NM; i++) begin
            if (smp_rdy[i]) begin
                drop_req[i] = 1'b1;
                ready_cnt[i]++;
            end
        end
        @(posedge ACLK);
        #1;
        for (int i = 0; i < NM; i++) begin
            if (drop_req[i]) begin
                drop_req[i] = 1'b0;
                if (rep_left[i] > 0) rep_left[i]--;
                else bus.M_AWVALID[i] = 1'b0;
            end
        end
    endtask

    task automatic push_exp(input int m, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size);
        exp_t          e;
        logic [7:0]    rem;
        logic [AW-1:0] a;
        logic          done;
        rem  = len;
        a    = addr;
        done = 1'b0;
        while (!done) begin
            e.addr = a;
            e.id   = IDW'(m);
            if (rem > 8'(MAXL)) begin
                e.len   = 8'(MAXL);
                e.split = 1'b1;
                rem     = rem - 8'(MAXL + 1);
                a       = a + (AW'(MAXL + 1) << size);
            end else begin
                e.len   = rem;
                e.split = 1'b0;
                done    = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic drive(input int m, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input int reps);
        bus.M_AWADDR[m*AW +: AW] = addr;
        bus.M_AWLEN[m*8 +: 8]    = len;
        bus.M_AWSIZE[m*3 +: 3]   = size;
        rep_left[m]              = reps;
        bus.M_AWVALID[m]         = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.M_AWVALID != '0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'(sb.size()) + 64'(bus.M_AWVALID), 64'(0));
    endtask

    initial begin
        int g0;
        int r0;
        int b;
        int n;

        bus.M_AWVALID     = '0;
        bus.M_AWADDR      = '0;
        bus.M_AWLEN       = '0;
        bus.M_AWSIZE      = '0;
        bus.S_AWREADY     = 1'b1;
        bus.Queue_Is_Full = 1'b0;
        drop_req          = '0;
        for (int i = 0; i < NM; i++) begin
            rep_left[i]  = 0;
            ready_cnt[i] = 0;
        end

        // Reset state
        tick();
        tick();
        chk("rst_s_awvalid", 64'(smp_vld), 64'(0));
        chk("rst_s_awaddr", 64'(smp_addr), 64'(0));
        chk("rst_s_awlen", 64'(smp_len), 64'(0));
        chk("rst_slave_id", 64'(smp_id), 64'(0));
        chk("rst_split", 64'(smp_split), 64'(0));
        chk("rst_grant", 64'(smp_grant), 64'(0));
        chk("rst_m_awready", 64'(smp_rdy), 64'(0));
        ARESETN = 1'b1;
        tick();

        // Single short burst from M0
        push_exp(0, 32'h1000, 8'd3, 3'd2);
        drive(0, 32'h1000, 8'd3, 3'd2, 0);
        wait_idle(20);

        // Long burst from M1 split into 15/15/8
        r0 = ready_cnt[1];
        g0 = grants;
        push_exp(1, 32'h2000, 8'd40, 3'd2);
        drive(1, 32'h2000, 8'd40, 3'd2, 0);
        wait_idle(40);
        chk("split_grant_count", 64'(grants - g0), 64'(3));
        chk("split_m1_ready_pulses", 64'(ready_cnt[1] - r0), 64'(1));

        // Both masters requesting continuously: alternate with a one-cycle gap
        b = grant_cyc.size();
        push_exp(0, 32'h3000, 8'd0, 3'd2);
        push_exp(1, 32'h4000, 8'd0, 3'd2);
        push_exp(0, 32'h3000, 8'd0, 3'd2);
        push_exp(1, 32'h4000, 8'd0, 3'd2);
        drive(0, 32'h3000, 8'd0, 3'd2, 1);
        drive(1, 32'h4000, 8'd0, 3'd2, 1);
        wait_idle(40);
        chk("rr_grant_count", 64'(grant_cyc.size() - b), 64'(4));
        if (grant_cyc.size() - b == 4) begin
            for (int k = 1; k < 4; k++) begin
                chk("rr_grant_gap", 64'(grant_cyc[b+k] - grant_cyc[b+k-1]), 64'(2));
            end
        end

        // Queue full holds off the slave request
        bus.Queue_Is_Full = 1'b1;
        push_exp(0, 32'h5000, 8'd2, 3'd1);
        drive(0, 32'h5000, 8'd2, 3'd1, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("full_s_awvalid", 64'(smp_vld), 64'(0));
        end
        bus.Queue_Is_Full = 1'b0;
        tick();
        chk("full_release_vld", 64'(smp_vld), 64'(1));
        chk("full_release_grant", 64'(smp_grant), 64'(1));
        wait_idle(20);

        // Slave backpressure: payload stable, exactly one grant
        bus.S_AWREADY = 1'b0;
        g0 = grants;
        push_exp(1, 32'h6000, 8'd5, 3'd3);
        drive(1, 32'h6000, 8'd5, 3'd3, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_s_awvalid", 64'(smp_vld), 64'(1));
            chk("bp_s_awaddr", 64'(smp_addr), 64'(32'h6000));
            chk("bp_s_awlen", 64'(smp_len), 64'(5));
        end
        chk("bp_no_grant", 64'(grants - g0), 64'(0));
        bus.S_AWREADY = 1'b1;
        wait_idle(20);
        chk("bp_one_grant", 64'(grants - g0), 64'(1));

        // Reset in the middle of a split, then M0 must win first
        g0 = grants;
        push_exp(1, 32'h2000, 8'd40, 3'd2);
        drive(1, 32'h2000, 8'd40, 3'd2, 0);
        n = 0;
        while (grants == g0 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_split_first_grant", 64'(grants - g0), 64'(1));
        sb.delete();
        bus.M_AWVALID = '0;
        ARESETN       = 1'b0;
        tick();
        chk("midrst_s_awvalid", 64'(smp_vld), 64'(0));
        chk("midrst_s_awaddr", 64'(smp_addr), 64'(0));
        chk("midrst_s_awlen", 64'(smp_len), 64'(0));
        chk("midrst_split", 64'(smp_split), 64'(0));
        chk("midrst_grant", 64'(smp_grant), 64'(0));
        chk("midrst_m_awready", 64'(smp_rdy), 64'(0));
        ARESETN = 1'b1;
        push_exp(0, 32'h8000, 8'd0, 3'd0);
        push_exp(1, 32'h7000, 8'd0, 3'd0);
        drive(1, 32'h7000, 8'd0, 3'd0, 0);
        drive(0, 32'h8000, 8'd0, 3'd0, 0);
        wait_idle(30);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
